// File: rtl/csi_rx_pkg.sv
// csi_rx_pkg: shared types and widths for the CSI-2 RX line FIFO.
package csi_rx_pkg;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 16;
    localparam int DESC_FIELD_W = 16;

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PIX_LO,
        ST_PIX_HI
    } rd_state_t;

    // One committed line: start word address and length in words.
    typedef struct packed {
        logic [DESC_FIELD_W-1:0] addr;
        logic [DESC_FIELD_W-1:0] len;
    } line_desc_t;

endpackage

// File: rtl/csi_rx_sdp_ram.sv
// csi_rx_sdp_ram: simple dual-port payload RAM, one write port, one registered read port.
module csi_rx_sdp_ram
    import csi_rx_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port and enabled synchronous read port; rd_data holds while rd_en is low.
    // NOTE: storage arrays carry no reset so they map onto block RAM; readers never
    // consume a word that was not written first.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/csi_rx_line_fifo.sv
// csi_rx_line_fifo: captures RAW8 payload words per packet, commits whole packets
// as lines and replays them as an 8-bit pixel stream with sol/eol/sof markers.
// Optional statistics outputs: define CSI_RX_LINE_FIFO_STATS_EN.
module csi_rx_line_fifo
    import csi_rx_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int DESC_DEPTH      = 4,
    parameter int LINES_PER_FRAME = 480,
    parameter int IDLE_GAP        = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] payload_in,
    input  logic              payload_valid,
    input  logic              packet_done,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_sof,
    output logic [7:0]        drop_cnt,
    output logic [11:0]       line_cnt
);

    localparam int ADDR_W  = $clog2(DEPTH_WORDS);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int DESC_AW = $clog2(DESC_DEPTH);
    localparam int DCNT_W  = DESC_AW + 1;
    localparam int IDLE_W  = $clog2(IDLE_GAP + 1);
    localparam logic [11:0] LINE_LAST = 12'(LINES_PER_FRAME - 1);

    // Write side
    logic [PTR_W-1:0] wr_ptr, rd_ptr, commit_ptr, pkt_len;
    logic             pkt_err, full, wr_fire, wr_over, pkt_bad, desc_push, pkt_drop;

    // Descriptor FIFO
    line_desc_t          desc_mem [DESC_DEPTH];
    line_desc_t          desc_head, new_desc;
    logic [DESC_AW-1:0]  desc_wr_idx, desc_rd_idx;
    logic [DCNT_W-1:0]   desc_count;
    logic                desc_full, desc_pop, desc_avail;

    // Read side
    rd_state_t          state, state_nxt;
    logic [PTR_W-1:0]   words_left;
    logic               first_word, last_word, lo_accept, hi_accept, eol_accept;
    logic [PIX_W-1:0]   hi_byte;
    logic               ram_rd_en;
    logic [ADDR_W-1:0]  ram_rd_addr;
    logic [WORD_W-1:0]  ram_rd_data;

    // Frame tracking
    logic [IDLE_W-1:0]  idle_cnt;
    logic               idle_hit, frame_pending;
    logic [11:0]        line_idx;

    assign full      = (wr_ptr - rd_ptr) == PTR_W'(DEPTH_WORDS);
    assign wr_fire   = payload_valid & ~full;
    assign wr_over   = payload_valid & full;
    // A word arriving with packet_done still belongs to the closing packet.
    assign pkt_len   = wr_ptr - commit_ptr + PTR_W'(wr_fire);
    assign pkt_bad   = pkt_err | wr_over;
    assign desc_full = desc_count == DCNT_W'(DESC_DEPTH);
    assign desc_push = packet_done & (pkt_len != '0) & ~pkt_bad & ~desc_full;
    assign pkt_drop  = packet_done & ((pkt_len != '0) | pkt_bad) & ~desc_push;
    assign new_desc  = {DESC_FIELD_W'(commit_ptr[ADDR_W-1:0]), DESC_FIELD_W'(pkt_len)};

    csi_rx_sdp_ram #(.DEPTH(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_ram (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (payload_in),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // Packet capture: advance on writes, roll back on discard, commit on good close.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_err    <= 1'b0;
        end else begin
            if (pkt_drop) begin
                wr_ptr <= commit_ptr;
            end else if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (desc_push) begin
                commit_ptr <= wr_ptr + PTR_W'(wr_fire);
            end
            if (packet_done) begin
                pkt_err <= 1'b0;
            end else if (wr_over) begin
                pkt_err <= 1'b1;
            end
        end
    end

    assign desc_head  = desc_mem[desc_rd_idx];
    assign desc_pop   = (state == ST_LOAD);
    assign desc_avail = (desc_count != '0) | desc_push;

    // Descriptor storage, written on commit.
    always_ff @(posedge clock) begin
        if (desc_push) begin
            desc_mem[desc_wr_idx] <= new_desc;
        end
    end

    // Descriptor FIFO indices and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            desc_wr_idx <= '0;
            desc_rd_idx <= '0;
            desc_count  <= '0;
        end else begin
            if (desc_push) desc_wr_idx <= desc_wr_idx + DESC_AW'(1);
            if (desc_pop)  desc_rd_idx <= desc_rd_idx + DESC_AW'(1);
            desc_count <= desc_count + DCNT_W'(desc_push) - DCNT_W'(desc_pop);
        end
    end

    assign last_word  = words_left == PTR_W'(1);
    assign lo_accept  = (state == ST_PIX_LO) & pix_ready;
    assign hi_accept  = (state == ST_PIX_HI) & pix_ready;
    assign eol_accept = hi_accept & last_word;
    assign pix_sof    = pix_sol & (line_idx == '0);

    // Read sequencer next state, RAM read issue and pixel outputs.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt   = state;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_ptr[ADDR_W-1:0];
        pix_valid   = 1'b0;
        pix_out     = '0;
        pix_sol     = 1'b0;
        pix_eol     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (desc_avail) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = ADDR_W'(desc_head.addr);
                state_nxt   = ST_PIX_LO;
            end
            ST_PIX_LO: begin
                pix_valid = 1'b1;
                pix_out   = ram_rd_data[PIX_W-1:0];
                pix_sol   = first_word;
                if (pix_ready) begin
                    // Prefetch the next word now; the high byte is held in hi_byte.
                    state_nxt   = ST_PIX_HI;
                    ram_rd_en   = ~last_word;
                    ram_rd_addr = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
                end
            end
            ST_PIX_HI: begin
                pix_valid = 1'b1;
                pix_out   = hi_byte;
                pix_eol   = last_word;
                if (pix_ready) begin
                    if (!last_word)     state_nxt = ST_PIX_LO;
                    else if (desc_avail) state_nxt = ST_LOAD;
                    else                state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read sequencer state, word bookkeeping and freeing of consumed words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            words_left <= '0;
            first_word <= 1'b0;
            hi_byte    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD) begin
                words_left <= PTR_W'(desc_head.len);
                first_word <= 1'b1;
            end
            if (lo_accept) begin
                first_word <= 1'b0;
                hi_byte    <= ram_rd_data[WORD_W-1:PIX_W];
            end
            if (hi_accept) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                words_left <= words_left - PTR_W'(1);
            end
        end
    end

    assign idle_hit = ~payload_valid & (idle_cnt == IDLE_W'(IDLE_GAP - 1));

    // Frame tracking: idle gap arms a new frame, lines counted modulo LINES_PER_FRAME.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt      <= '0;
            frame_pending <= 1'b1;
            line_idx      <= '0;
        end else begin
            if (payload_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(IDLE_GAP)) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            if (idle_hit) begin
                frame_pending <= 1'b1;
            end else if (state == ST_LOAD) begin
                frame_pending <= 1'b0;
            end
            if ((state == ST_LOAD) && frame_pending) begin
                line_idx <= '0;
            end else if (eol_accept) begin
                line_idx <= (line_idx == LINE_LAST) ? '0 : line_idx + 12'd1;
            end
        end
    end

`ifdef CSI_RX_LINE_FIFO_STATS_EN
    logic [7:0] drop_q;

    // Saturating count of discarded packets.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (pkt_drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
    assign line_cnt = line_idx;
`else
    assign drop_cnt = '0;
    assign line_cnt = '0;
`endif

endmodule
